// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306-class 6800 parallel driver.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_CMD,
        ST_FRAME
    } state_t;

    localparam int ROM_DEPTH = 32;

    localparam logic [7:0] INIT_ROM [0:ROM_DEPTH-1] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
        8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
        8'hAF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam int E_RISE_PHASE = 1;

    function automatic int e_fall_phase(input int e_high_clks);
        return e_high_clks + 1;
    endfunction

    function automatic int cs_rise_phase(input int clk_per_byte);
        return clk_per_byte - 1;
    endfunction

endpackage

// File: rtl/oled_byte_slot.sv
// One 6800 bus write slot: cs low for the slot, e pulse, data/dc held
// from slot start until the next slot is launched.
module oled_byte_slot
    import oled_pkg::*;
#(
    parameter int CLK_PER_BYTE = 16,
    parameter int E_HIGH_CLKS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] byte_data,
    input  logic       dc,
    output logic       slot_start,
    output logic       slot_end,
    output logic       free,
    output logic       oled_cs,
    output logic       oled_e,
    output logic       oled_dc,
    output logic [7:0] oled_data
);

    localparam int SW = $clog2(CLK_PER_BYTE);
    localparam logic [SW-1:0] LAST   = SW'(cs_rise_phase(CLK_PER_BYTE));
    localparam logic [SW-1:0] E_RISE = SW'(E_RISE_PHASE);
    localparam logic [SW-1:0] E_FALL = SW'(e_fall_phase(E_HIGH_CLKS));

    logic          active;
    logic          active_n;
    logic [SW-1:0] s;
    logic [SW-1:0] s_n;

    assign slot_start = active && (s == '0);
    assign slot_end   = active && (s == LAST);
    // A new slot may launch on the final phase, giving gapless slots.
    assign free       = !active || slot_end;

    always_comb begin
        active_n = active;
        s_n      = s;
        if (go) begin
            active_n = 1'b1;
            s_n      = '0;
        end else if (slot_end) begin
            active_n = 1'b0;
            s_n      = '0;
        end else if (active) begin
            s_n = s + SW'(1);
        end
    end

    // Pin outputs are registered from the next phase so they line up with s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active    <= 1'b0;
            s         <= '0;
            oled_cs   <= 1'b1;
            oled_e    <= 1'b0;
            oled_dc   <= 1'b0;
            oled_data <= 8'h00;
        end else begin
            active  <= active_n;
            s       <= s_n;
            oled_cs <= !(active_n && (s_n != LAST));
            oled_e  <= active_n && (s_n >= E_RISE) && (s_n < E_FALL);
            if (go) begin
                oled_dc   <= dc;
                oled_data <= byte_data;
            end
        end
    end

endmodule

// File: rtl/oled_par_stream_ctrl.sv
// Panel reset, init ROM playback, runtime commands and frame streaming
// over a 6800-style parallel bus.
module oled_par_stream_ctrl
    import oled_pkg::*;
#(
    parameter int CLK_PER_BYTE  = 16,
    parameter int E_HIGH_CLKS   = 8,
    parameter int RST_LOW_CLKS  = 3,
    parameter int RST_WAIT_CLKS = 64,
    parameter int INIT_LEN      = 25,
    parameter int FB_BYTES      = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       init_done,
    output logic       busy,
    output logic       frame_done,
    output logic       oled_dc,
    output logic       oled_rw,
    output logic       oled_cs,
    output logic       oled_e,
    output logic       oled_reset,
    output logic [7:0] oled_data
);

    localparam int PW = $clog2(FB_BYTES + 1);
    localparam int CNT_MAX =
        (RST_LOW_CLKS > RST_WAIT_CLKS) ? RST_LOW_CLKS : RST_WAIT_CLKS;
    localparam int CW = $clog2(CNT_MAX + 1);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [5:0]    rom_idx;
    logic [5:0]    rom_idx_n;
    logic [PW-1:0] pix_idx;
    logic [PW-1:0] pix_idx_n;
    logic          init_done_n;
    logic          frame_done_n;
    logic          go;
    logic          slot_dc;
    logic [7:0]    slot_data;
    logic          slot_start;
    logic          slot_end;
    logic          free;

    assign oled_rw = 1'b0;

    oled_byte_slot #(
        .CLK_PER_BYTE(CLK_PER_BYTE),
        .E_HIGH_CLKS (E_HIGH_CLKS)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .byte_data (slot_data),
        .dc        (slot_dc),
        .slot_start(slot_start),
        .slot_end  (slot_end),
        .free      (free),
        .oled_cs   (oled_cs),
        .oled_e    (oled_e),
        .oled_dc   (oled_dc),
        .oled_data (oled_data)
    );

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        rom_idx_n    = rom_idx;
        pix_idx_n    = pix_idx;
        init_done_n  = init_done;
        frame_done_n = 1'b0;
        go           = 1'b0;
        slot_dc      = 1'b0;
        slot_data    = 8'h00;
        cmd_ready    = 1'b0;
        pix_ready    = 1'b0;
        unique case (state)
            ST_RST_LOW: begin
                if (cnt == CW'(RST_LOW_CLKS)) begin
                    state_n = ST_RST_WAIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_RST_WAIT: begin
                if (cnt == CW'(RST_WAIT_CLKS - 1)) begin
                    state_n   = ST_INIT;
                    cnt_n     = '0;
                    rom_idx_n = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_INIT: begin
                slot_data = INIT_ROM[rom_idx[4:0]];
                if (slot_start) begin
                    rom_idx_n = rom_idx + 6'd1;
                end
                if ((rom_idx == 6'(INIT_LEN)) && slot_end) begin
                    state_n     = ST_IDLE;
                    init_done_n = 1'b1;
                end else if (free && (rom_idx < 6'(INIT_LEN))) begin
                    go = 1'b1;
                end
            end
            ST_IDLE: begin
                // Commands win; a simultaneous frame_start is dropped.
                if (cmd_valid) begin
                    cmd_ready = 1'b1;
                    go        = 1'b1;
                    slot_data = cmd_data;
                    state_n   = ST_CMD;
                end else if (frame_start) begin
                    state_n   = ST_FRAME;
                    pix_idx_n = '0;
                end
            end
            ST_CMD: begin
                if (slot_end) begin
                    state_n = ST_IDLE;
                end
            end
            ST_FRAME: begin
                slot_dc   = 1'b1;
                slot_data = pix_data;
                if (slot_start) begin
                    pix_idx_n = pix_idx + PW'(1);
                end
                if ((pix_idx == PW'(FB_BYTES)) && slot_end) begin
                    state_n      = ST_IDLE;
                    frame_done_n = 1'b1;
                end else if (free && pix_valid && (pix_idx < PW'(FB_BYTES))) begin
                    pix_ready = 1'b1;
                    go        = 1'b1;
                end
            end
            default: begin
                state_n = ST_RST_LOW;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RST_LOW;
            cnt        <= '0;
            rom_idx    <= '0;
            pix_idx    <= '0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            oled_reset <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rom_idx    <= rom_idx_n;
            pix_idx    <= pix_idx_n;
            init_done  <= init_done_n;
            frame_done <= frame_done_n;
            busy       <= (state_n != ST_IDLE);
            oled_reset <= (state_n != ST_RST_LOW);
        end
    end

endmodule
